// File: rtl/ecg_pkg.sv
// Shared ECG pipeline constants and types.
// Used by the R-peak detector and the apnea detector.
package ecg_pkg;

  localparam int SAMPLE_RATE_HZ = 100;
  localparam int RR_W           = 16;
  localparam int REFRACTORY_DEF = 20;
  localparam int RR_MAX_DEF     = 300;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    REFRACT
  } rpk_state_e;

  function automatic logic [15:0] floor_u16(
    input logic [15:0] v,
    input logic [15:0] lo
  );
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/ecg_slope_feature.sv
// Slope feature: |x[n] - x[n-2]|, saturated to 16 bits unsigned.
// Delay line advances only on sample_en.
module ecg_slope_feature
  import ecg_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en_i,
  input  logic signed [DATA_W-1:0] ecg_i,
  output logic [15:0]              f_o
);

  localparam int MW = (DATA_W + 1 > 16) ? DATA_W + 1 : 16;

  logic signed [DATA_W-1:0] x1_q;
  logic signed [DATA_W-1:0] x2_q;
  logic signed [DATA_W:0]   diff;
  logic [DATA_W:0]          mag;
  logic [MW-1:0]            mag_w;

  assign diff = $signed({ecg_i[DATA_W-1], ecg_i})
              - $signed({x2_q[DATA_W-1], x2_q});

  assign mag   = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
  assign mag_w = MW'(mag);

  assign f_o = (mag_w > MW'(16'hFFFF)) ? 16'hFFFF : mag_w[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_q <= '0;
      x2_q <= '0;
    end else if (sample_en_i) begin
      x2_q <= x1_q;
      x1_q <= ecg_i;
    end
  end

endmodule

// File: rtl/r_peak_detector.sv
// QRS peak detector: adaptive threshold, refractory blanking,
// RR interval counter and no-beat timeout.
module r_peak_detector
  import ecg_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REFRACTORY  = REFRACTORY_DEF,
  parameter int MAX_TRACK   = 10,
  parameter int RR_MAX      = RR_MAX_DEF,
  parameter int INIT_THRESH = 512,
  parameter int MIN_THRESH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic signed [DATA_W-1:0] ecg_in,
  output logic                     r_peak,
  output logic [RR_W-1:0]          rr_value,
  output logic                     no_beat,
  output logic [15:0]              threshold
);

  localparam int TRK_W = $clog2(MAX_TRACK + 1);
  localparam int REF_W = $clog2(REFRACTORY + 1);

  localparam logic [15:0]     MIN_T  = 16'(MIN_THRESH);
  localparam logic [RR_W-1:0] RR_TOP = RR_W'(RR_MAX);

  logic [15:0] f;

  rpk_state_e      state_q, state_d;
  logic [15:0]     pk_q, pk_d;
  logic [TRK_W-1:0] trk_q, trk_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic [16:0]     spk_q, spk_d;
  logic [15:0]     thr_q, thr_d;
  logic [RR_W-1:0] rr_q, rr_d;
  logic [RR_W-1:0] rrv_q, rrv_d;
  logic            primed_q, primed_d;
  logic            pend_q, pend_d;
  logic            nobeat_q, nobeat_d;
  logic            tout_q, tout_d;

  logic [15:0]     pk_max;
  logic [16:0]     spk_decl;
  logic [15:0]     thr_decl;
  logic [15:0]     thr_half;
  logic [RR_W:0]   rr_p1;
  logic [RR_W-1:0] rr_inc;
  logic            decl;

  ecg_slope_feature #(
    .DATA_W(DATA_W)
  ) u_slope (
    .clk        (clk),
    .rst        (rst),
    .sample_en_i(sample_en),
    .ecg_i      (ecg_in),
    .f_o        (f)
  );

  assign pk_max = (f > pk_q) ? f : pk_q;

  // Leaky peak average: spk += (pk - spk) / 8
  assign spk_decl = spk_q
                  - {3'b000, spk_q[16:3]}
                  + {4'b0000, pk_max[15:3]};

  assign thr_decl = floor_u16(spk_decl[16:1], MIN_T);
  assign thr_half = floor_u16({1'b0, thr_q[15:1]}, MIN_T);

  assign rr_p1  = {1'b0, rr_q} + 1'b1;
  assign rr_inc = (rr_p1 >= {1'b0, RR_TOP}) ? RR_TOP
                                            : rr_p1[RR_W-1:0];

  always_comb begin
    state_d  = state_q;
    pk_d     = pk_q;
    trk_d    = trk_q;
    ref_d    = ref_q;
    spk_d    = spk_q;
    thr_d    = thr_q;
    rr_d     = rr_q;
    rrv_d    = rrv_q;
    primed_d = primed_q;
    pend_d   = pend_q;
    nobeat_d = nobeat_q;
    tout_d   = tout_q;
    decl     = 1'b0;

    if (sample_en) begin
      pend_d = 1'b0;

      unique case (state_q)
        SEARCH: begin
          if (f >= thr_q) begin
            state_d = TRACK;
            pk_d    = f;
            trk_d   = TRK_W'(1);
          end
        end
        TRACK: begin
          pk_d = pk_max;
          if (f < (pk_q >> 1) ||
              trk_q == TRK_W'(MAX_TRACK)) begin
            decl = 1'b1;
          end else begin
            trk_d = trk_q + 1'b1;
          end
        end
        REFRACT: begin
          if (ref_q == REF_W'(REFRACTORY - 1)) begin
            state_d = SEARCH;
            ref_d   = '0;
          end else begin
            ref_d = ref_q + 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase

      if (decl) begin
        spk_d    = spk_decl;
        thr_d    = thr_decl;
        state_d  = REFRACT;
        ref_d    = '0;
        rr_d     = '0;
        nobeat_d = 1'b0;
        tout_d   = 1'b0;
        if (primed_q) begin
          rrv_d  = rr_inc;
          pend_d = 1'b1;
        end else begin
          primed_d = 1'b1;
        end
      end else begin
        rr_d = rr_inc;
        if (rr_inc == RR_TOP) begin
          nobeat_d = 1'b1;
        end
        // Relax threshold once per silent stretch
        if (rr_inc == RR_TOP && state_q == SEARCH &&
            !tout_q) begin
          thr_d  = thr_half;
          spk_d  = {1'b0, thr_q};
          tout_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      pk_q     <= '0;
      trk_q    <= '0;
      ref_q    <= '0;
      spk_q    <= 17'(2 * INIT_THRESH);
      thr_q    <= 16'(INIT_THRESH);
      rr_q     <= '0;
      rrv_q    <= '0;
      primed_q <= 1'b0;
      pend_q   <= 1'b0;
      nobeat_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pk_q     <= pk_d;
      trk_q    <= trk_d;
      ref_q    <= ref_d;
      spk_q    <= spk_d;
      thr_q    <= thr_d;
      rr_q     <= rr_d;
      rrv_q    <= rrv_d;
      primed_q <= primed_d;
      pend_q   <= pend_d;
      nobeat_q <= nobeat_d;
      tout_q   <= tout_d;
    end
  end

  assign r_peak    = pend_q & sample_en;
  assign rr_value  = rrv_q;
  assign no_beat   = nobeat_q;
  assign threshold = thr_q;

endmodule

// File: doc/r_peak_detector.md
Name: r_peak_detector

Overview:
- Producer side of the r_peak/rr_value beat interface consumed by the apnea detector.
- Takes filtered, signed ECG samples at the 100 Hz sample_en rate and computes a slope feature.
- Finds QRS peaks using an adaptive threshold and a refractory period.
- Emits a 1-cycle r_peak strobe, aligned to sample_en, and rr_value, the interval in samples since the previous beat.

Parameters:
- DATA_W, 16, width of signed ECG input sample.
- REFRACTORY, 20, samples after a declared peak during which detection is blocked (200 ms).
- MAX_TRACK, 10, maximum samples spent tracking one peak before forced declaration.
- RR_MAX, 300, rr counter saturation value (3 s); also the no-beat timeout.
- INIT_THRESH, 512, threshold after reset.
- MIN_THRESH, 64, floor for the adaptive threshold.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  one-cycle 100 Hz sample strobe.
- ecg_in  in  DATA_W  signed sample, valid when sample_en=1.
- r_peak  out  1  beat strobe, high only in a cycle where sample_en=1.
- rr_value  out  16  RR interval in samples; stable whenever r_peak=1.
- no_beat  out  1  level; high while rr counter is saturated at RR_MAX.
- threshold  out  16  current detection threshold (debug/monitor).

Behaviour:
- All state advances only on cycles with sample_en=1. Cycles without sample_en hold all state.
- Reset values: r_peak=0, rr_value=0, no_beat=0, threshold=INIT_THRESH, spk=2*INIT_THRESH, rr_count=0, primed=0, pending=0, x1=x2=0, state=SEARCH.
- Feature: f = |ecg_in - x2|, where x2 is the sample two ticks earlier. Computed at 17 bits and saturated to 16 unsigned. Shift x2<=x1, x1<=ecg_in every tick.
- FSM states:
  - SEARCH: if f >= threshold, go to TRACK with pk=f and trk=1.
  - TRACK: if f > pk then pk<=f. Declare a peak when f < (pk>>1) or trk == MAX_TRACK; otherwise trk++.
  - REFRACT: count REFRACTORY ticks, ignoring f, then go to SEARCH. rr_count keeps running.
- Declaration, on a tick:
  - spk <= spk - (spk>>3) + (pk>>3).
  - threshold <= max(spk_new>>1, MIN_THRESH).
  - go to REFRACT.
  - If primed=1: rr_value <= rr_count+1 (saturated to RR_MAX), pending<=1.
  - If primed=0: primed<=1 and no strobe. The first beat after reset only arms the detector.
  - rr_count <= 0.
- Non-declaring tick: rr_count <= min(rr_count+1, RR_MAX).
- r_peak = pending & sample_en, i.e. asserted on the next sample_en after declaration (one sample of latency). pending clears on that tick. This guarantees that a consumer gated by sample_en captures the strobe.
- rr_value is registered at declaration and holds until the next declaration.
- Timeout: on the tick where rr_count reaches RR_MAX while in SEARCH:
  - threshold <= max(threshold>>1, MIN_THRESH), once per saturation episode.
  - spk <= threshold (the value before halving).
  - no_beat=1 until the next declaration.
- Simultaneous events: declaration and timeout on the same tick means declaration wins; no_beat clears.
- rst mid-operation: an immediate return to reset values. Any pending strobe is dropped.
- Arithmetic: spk is 17 bits with no overflow, given the 16-bit pk.

Decomposition:
- Shared package ecg_pkg holds:
  - SAMPLE_RATE_HZ=100.
  - RR_W=16.
  - the state enum {SEARCH, TRACK, REFRACT}.
  - the default REFRACTORY and RR_MAX constants, shared with apnea_detection thresholds.
- One natural sub-module: ecg_slope_feature. It contains the x1/x2 delay line plus the saturated abs-difference and outputs f. The FSM, adaptive threshold and rr counter stay in the top.

Test Plan:
- Reset, then a pulse train of amplitude 4000 with 2-sample rise, one every 100 samples.
  - The first pulse produces no r_peak.
  - Each later pulse produces exactly one r_peak with rr_value=100, coincident with sample_en.
- Pulse train at 80 samples, then at 120 samples.
  - rr_value sequence is ...,80,80,120,120, with no missed or doubled strobes.
- Second spike placed 10 samples after a detected beat (inside REFRACTORY).
  - No r_peak is produced, and the following rr_value counts from the real beat.
- Flat input for 400 samples after a beat.
  - no_beat rises at tick 300.
  - threshold halves once, and never drops below 64.
  - The next pulse gives rr_value=300 and no_beat=0.
- Plateau input with f held above threshold for 15 samples.
  - Forced declaration after MAX_TRACK=10 samples.
  - Exactly one strobe.
- Assert rst while pending=1 and between sample_en pulses.
  - No r_peak appears.
  - Outputs return to reset values asynchronously.
  - The next beat is treated as first (no strobe).
